// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: 16x-style centre sampling, parity/framing/break status,
// valid/ready holding register with overrun pulse.
module uart_rx_cfg #(
  parameter int unsigned ClkFrequency = 50000000,
  parameter int unsigned Baud         = 115200,
  parameter int unsigned Oversampling = 16,
  parameter int unsigned DataBits     = 8,
  parameter int unsigned Parity       = 0,
  parameter int unsigned StopBits     = 1,
  parameter int unsigned AccWidth     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                RxD,
  input  logic                rx_ready,
  output logic                rx_valid,
  output logic [DataBits-1:0] rx_data,
  output logic                rx_parity_err,
  output logic                rx_frame_err,
  output logic                rx_break,
  output logic                rx_overrun,
  output logic                rx_busy
);

  // 64-bit elaboration arithmetic keeps Baud*Oversampling*2^AccWidth from overflowing.
  localparam logic [63:0] IncFull =
    (((64'(Baud) * 64'(Oversampling)) << AccWidth) + 64'(ClkFrequency / 2)) / 64'(ClkFrequency);
  localparam logic [AccWidth:0]  Inc      = IncFull[AccWidth:0];
  localparam int unsigned        PhW      = $clog2(Oversampling);
  localparam logic [PhW-1:0]     SamplePh = PhW'(Oversampling / 2 - 1);
  localparam logic [3:0]         LastBit  = 4'(DataBits - 1);
  localparam logic               OddPar   = (Parity == 2);

  if (Oversampling < 8 || (Oversampling & (Oversampling - 1)) != 0) begin : g_badOsr
    $error("Oversampling must be a power of 2 and >= 8");
  end
  if (DataBits < 5 || DataBits > 9) begin : g_badData
    $error("DataBits must be 5..9");
  end
  if (Parity > 2) begin : g_badParity
    $error("Parity must be 0, 1 or 2");
  end
  if (StopBits < 1 || StopBits > 2) begin : g_badStop
    $error("StopBits must be 1 or 2");
  end
  if (IncFull == 0 || IncFull > (64'd1 << AccWidth)) begin : g_badInc
    $error("Baud increment out of range for AccWidth");
  end

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2, DONE, WAIT_HIGH
  } state_t;

  state_t state, nextState;

  logic [AccWidth:0]   acc;
  logic                tick;
  logic                s1, s;
  logic [PhW-1:0]      ph;
  logic                sample;
  logic [DataBits-1:0] shreg;
  logic [3:0]          bitCnt;
  logic                parErr, frmErr, anyHigh;
  logic                isDone;

  always_ff @(posedge clk) begin
    if (rst) acc <= '0;
    else     acc <= {1'b0, acc[AccWidth-1:0]} + Inc;
  end
  assign tick = acc[AccWidth];

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      s  <= 1'b1;
    end else begin
      s1 <= RxD;
      s  <= s1;
    end
  end

  assign sample = tick && (ph == SamplePh);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:      if (!s) nextState = START;
      START:     if (sample) nextState = s ? IDLE : DATA;
      DATA:      if (sample && bitCnt == LastBit) nextState = (Parity != 0) ? PARITY : STOP1;
      PARITY:    if (sample) nextState = STOP1;
      STOP1:     if (sample) nextState = (StopBits == 2) ? STOP2 : DONE;
      STOP2:     if (sample) nextState = DONE;
      DONE:      nextState = s ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (s) nextState = IDLE;
      default:   nextState = IDLE;
    endcase
  end

  always_comb begin
    rx_busy = (state != IDLE);
    isDone  = (state == DONE);
  end

  // Frame accumulation; anyHigh records any high data/parity/stop sample, so break = !anyHigh.
  always_ff @(posedge clk) begin
    if (rst) begin
      ph      <= '0;
      shreg   <= '0;
      bitCnt  <= '0;
      parErr  <= 1'b0;
      frmErr  <= 1'b0;
      anyHigh <= 1'b0;
    end else begin
      if (state == IDLE) begin
        ph      <= '0;
        bitCnt  <= '0;
        parErr  <= 1'b0;
        frmErr  <= 1'b0;
        anyHigh <= 1'b0;
      end else if (tick) begin
        ph <= ph + 1'b1;
      end
      if (sample) begin
        case (state)
          DATA: begin
            shreg   <= {s, shreg[DataBits-1:1]};
            bitCnt  <= bitCnt + 4'd1;
            anyHigh <= anyHigh | s;
          end
          PARITY: begin
            parErr  <= (^{shreg, s}) ^ OddPar;
            anyHigh <= anyHigh | s;
          end
          STOP1, STOP2: begin
            if (!s) frmErr <= 1'b1;
            anyHigh <= anyHigh | s;
          end
          default: ;
        endcase
      end
    end
  end

  // A frame completing while the held one is being accepted loads in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid      <= 1'b0;
      rx_data       <= '0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_break      <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (isDone) begin
        if (!rx_valid || rx_ready) begin
          rx_valid      <= 1'b1;
          rx_data       <= shreg;
          rx_parity_err <= parErr;
          rx_frame_err  <= frmErr;
          rx_break      <= !anyHigh;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: an 8N1 instance and a 7E2 instance at 16 clk per bit.
module tb_uart_rx_cfg;

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxA = 1'b1, rxB = 1'b1;
  logic readyA = 1'b1, readyB = 1'b1;

  logic       aValid, aPerr, aFerr, aBrk, aOverrun, aBusy;
  logic [7:0] aData;
  logic       bValid, bPerr, bFerr, bBrk, bOverrun, bBusy;
  logic [6:0] bData;

  int vectors = 0;
  int miscompares = 0;
  int ovCount = 0;
  frame_t qA[$];
  frame_t qB[$];

  always #5 clk = ~clk;

  uart_rx_cfg #(
    .ClkFrequency(1843200), .Baud(115200), .Oversampling(16),
    .DataBits(8), .Parity(0), .StopBits(1), .AccWidth(16)
  ) dutA (
    .clk(clk), .rst(rst), .RxD(rxA), .rx_ready(readyA),
    .rx_valid(aValid), .rx_data(aData), .rx_parity_err(aPerr),
    .rx_frame_err(aFerr), .rx_break(aBrk), .rx_overrun(aOverrun), .rx_busy(aBusy)
  );

  uart_rx_cfg #(
    .ClkFrequency(1843200), .Baud(115200), .Oversampling(16),
    .DataBits(7), .Parity(1), .StopBits(2), .AccWidth(16)
  ) dutB (
    .clk(clk), .rst(rst), .RxD(rxB), .rx_ready(readyB),
    .rx_valid(bValid), .rx_data(bData), .rx_parity_err(bPerr),
    .rx_frame_err(bFerr), .rx_break(bBrk), .rx_overrun(bOverrun), .rx_busy(bBusy)
  );

  // Scoreboard pop on every transfer, one monitor per instance.
  always @(negedge clk) begin
    if (!rst && aValid && readyA) begin
      frame_t got, exp;
      got = '{data: {1'b0, aData}, perr: aPerr, ferr: aFerr, brk: aBrk};
      vectors++;
      if (qA.size() == 0) begin
        miscompares++;
        $display("FAIL frameA_unexpected got=%h required=none", got);
      end else begin
        exp = qA.pop_front();
        if (got !== exp) begin
          miscompares++;
          $display("FAIL frameA got data=%h p=%b f=%b b=%b required data=%h p=%b f=%b b=%b",
                   got.data, got.perr, got.ferr, got.brk, exp.data, exp.perr, exp.ferr, exp.brk);
        end
      end
    end
    if (!rst && aOverrun === 1'b1) ovCount++;
  end

  always @(negedge clk) begin
    if (!rst && bValid && readyB) begin
      frame_t got, exp;
      got = '{data: {2'b0, bData}, perr: bPerr, ferr: bFerr, brk: bBrk};
      vectors++;
      if (qB.size() == 0) begin
        miscompares++;
        $display("FAIL frameB_unexpected got=%h required=none", got);
      end else begin
        exp = qB.pop_front();
        if (got !== exp) begin
          miscompares++;
          $display("FAIL frameB got data=%h p=%b f=%b b=%b required data=%h p=%b f=%b b=%b",
                   got.data, got.perr, got.ferr, got.brk, exp.data, exp.perr, exp.ferr, exp.brk);
        end
      end
    end
  end

  task automatic drive(input int dut, input logic v, input int clks);
    if (dut == 0) rxA = v;
    else          rxB = v;
    repeat (clks) @(posedge clk);
    #1;
  endtask

  task automatic sendFrame(input int dut, input logic [8:0] data, input int nbits,
                           input bit hasPar, input logic parBit, input int nstop,
                           input logic stopLvl);
    drive(dut, 1'b0, 16);
    for (int i = 0; i < nbits; i++) drive(dut, data[i], 16);
    if (hasPar) drive(dut, parBit, 16);
    for (int i = 0; i < nstop; i++) drive(dut, stopLvl, 16);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({aValid, aData, aPerr, aFerr, aBrk, aOverrun, aBusy} !== '0) begin
      miscompares++;
      $display("FAIL reset_A got=%b required=0", {aValid, aData, aPerr, aFerr, aBrk, aOverrun, aBusy});
    end
    vectors++;
    if ({bValid, bData, bPerr, bFerr, bBrk, bOverrun, bBusy} !== '0) begin
      miscompares++;
      $display("FAIL reset_B got=%b required=0", {bValid, bData, bPerr, bFerr, bBrk, bOverrun, bBusy});
    end
    rst = 1'b0;
    drive(0, 1'b1, 20);
  endtask

  task automatic test_back_to_back;
    qA.push_back('{data: 9'h0A5, perr: 1'b0, ferr: 1'b0, brk: 1'b0});
    qA.push_back('{data: 9'h03C, perr: 1'b0, ferr: 1'b0, brk: 1'b0});
    sendFrame(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1);
    sendFrame(0, 9'h03C, 8, 1'b0, 1'b0, 1, 1'b1);
    drive(0, 1'b1, 48);
    vectors++;
    if (qA.size() !== 0) begin
      miscompares++;
      $display("FAIL b2b_pending got=%0d required=0", qA.size());
    end
    vectors++;
    if (ovCount !== 0) begin
      miscompares++;
      $display("FAIL b2b_overrun got=%0d required=0", ovCount);
    end
  endtask

  task automatic test_parity;
    // 0x55 in 7 bits has four ones: even parity bit is 0.
    qB.push_back('{data: 9'h055, perr: 1'b0, ferr: 1'b0, brk: 1'b0});
    qB.push_back('{data: 9'h055, perr: 1'b1, ferr: 1'b0, brk: 1'b0});
    sendFrame(1, 9'h055, 7, 1'b1, 1'b0, 2, 1'b1);
    sendFrame(1, 9'h055, 7, 1'b1, 1'b1, 2, 1'b1);
    drive(1, 1'b1, 48);
    vectors++;
    if (qB.size() !== 0) begin
      miscompares++;
      $display("FAIL parity_pending got=%0d required=0", qB.size());
    end
  endtask

  task automatic test_frame_err;
    qA.push_back('{data: 9'h081, perr: 1'b0, ferr: 1'b1, brk: 1'b0});
    sendFrame(0, 9'h081, 8, 1'b0, 1'b0, 1, 1'b0);
    drive(0, 1'b1, 48);
    vectors++;
    if (qA.size() !== 0) begin
      miscompares++;
      $display("FAIL frame_err_pending got=%0d required=0", qA.size());
    end
  endtask

  task automatic test_break;
    qA.push_back('{data: 9'h000, perr: 1'b0, ferr: 1'b1, brk: 1'b1});
    drive(0, 1'b0, 40 * 16);
    vectors++;
    if (aBusy !== 1'b1) begin
      miscompares++;
      $display("FAIL break_busy_low got=%b required=1", aBusy);
    end
    drive(0, 1'b1, 4);
    vectors++;
    if (aBusy !== 1'b0) begin
      miscompares++;
      $display("FAIL break_busy_after got=%b required=0", aBusy);
    end
    drive(0, 1'b1, 160);
    vectors++;
    if (qA.size() !== 0) begin
      miscompares++;
      $display("FAIL break_pending got=%0d required=0", qA.size());
    end
  endtask

  task automatic test_glitch;
    drive(0, 1'b0, 5);
    drive(0, 1'b1, 9);
    vectors++;
    if (aBusy !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_busy got=%b required=0", aBusy);
    end
    drive(0, 1'b1, 16);
    qA.push_back('{data: 9'h012, perr: 1'b0, ferr: 1'b0, brk: 1'b0});
    sendFrame(0, 9'h012, 8, 1'b0, 1'b0, 1, 1'b1);
    drive(0, 1'b1, 32);
    vectors++;
    if (qA.size() !== 0) begin
      miscompares++;
      $display("FAIL glitch_pending got=%0d required=0", qA.size());
    end
  endtask

  task automatic test_overrun;
    readyA = 1'b0;
    qA.push_back('{data: 9'h011, perr: 1'b0, ferr: 1'b0, brk: 1'b0});
    sendFrame(0, 9'h011, 8, 1'b0, 1'b0, 1, 1'b1);
    sendFrame(0, 9'h022, 8, 1'b0, 1'b0, 1, 1'b1);
    drive(0, 1'b1, 32);
    vectors++;
    if (aValid !== 1'b1 || aData !== 8'h11) begin
      miscompares++;
      $display("FAIL overrun_hold got valid=%b data=%h required valid=1 data=11", aValid, aData);
    end
    vectors++;
    if (ovCount !== 1) begin
      miscompares++;
      $display("FAIL overrun_pulses got=%0d required=1", ovCount);
    end
    readyA = 1'b1;
    drive(0, 1'b1, 2);
    vectors++;
    if (aValid !== 1'b0 || qA.size() !== 0) begin
      miscompares++;
      $display("FAIL overrun_drain got valid=%b pending=%0d required valid=0 pending=0",
               aValid, qA.size());
    end
  endtask

  task automatic test_reset_midframe;
    readyA = 1'b0;
    sendFrame(0, 9'h033, 8, 1'b0, 1'b0, 1, 1'b1);
    drive(0, 1'b1, 16);
    drive(0, 1'b0, 16);
    drive(0, 1'b1, 24);
    rst = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if ({aValid, aData, aPerr, aFerr, aBrk, aOverrun, aBusy} !== '0) begin
      miscompares++;
      $display("FAIL rst_midframe got=%b required=0", {aValid, aData, aPerr, aFerr, aBrk, aOverrun, aBusy});
    end
    rst = 1'b0;
    readyA = 1'b1;
    drive(0, 1'b1, 200);
    vectors++;
    if (aValid !== 1'b0 || aBusy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_after got valid=%b busy=%b required 0 0", aValid, aBusy);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_back_to_back();
    test_parity();
    test_frame_err();
    test_break();
    test_glitch();
    test_overrun();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
